oled_glyph_sequencer: RTL and testbench

//  Sequences the OLED font ROM (font_sel/font_row/index -> registered data, 1-cycle latency) to render a

---
 rtl/oled_pkg.sv | 36 +++
 rtl/oled_glyph_sequencer_if.sv | 10 +
 rtl/oled_glyph_buf.sv | 22 ++
 rtl/oled_glyph_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_oled_glyph_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared panel constants, SSD1306 opcodes, FSM states and glyph width lookup
package oled_pkg;

  localparam int OLED_COLS  = 128;
  localparam int OLED_PAGES = 8;
  localparam int MAX_GLYPHS = 16;

  // SSD1306 page-addressing opcodes; the low bits are OR'ed in with page / column nibbles.
  localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO   = 8'h00;
  localparam logic [7:0] CMD_COL_HI   = 8'h10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_NEXT_GLYPH,
    S_CMD_PAGE,
    S_CMD_COLL,
    S_CMD_COLH,
    S_FETCH,
    S_DATA,
    S_NEXT_ROW,
    S_DONE
  } seq_state_t;

  // Column width of a glyph by font_sel; 0 marks an invalid code that renders nothing.
  function automatic logic [4:0] glyph_width(input logic [5:0] sel);
    logic [4:0] w;
    case (sel)
      6'd0, 6'd1, 6'd10, 6'd12, 6'd13, 6'd14:                       w = 5'd8;
      6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd11:          w = 5'd16;
      default:                                                        w = 5'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/oled_glyph_sequencer_if.sv
// rtl/oled_glyph_sequencer_if.sv - byte stream from the glyph sequencer to the serial OLED writer
interface oled_glyph_sequencer_if;
  logic       out_valid;
  logic       out_dc;
  logic [7:0] out_byte;
  logic       out_ready;

  modport master (output out_valid, output out_dc, output out_byte, input out_ready);
  modport slave  (input out_valid, input out_dc, input out_byte, output out_ready);
endinterface

// File: rtl/oled_glyph_buf.sv
// rtl/oled_glyph_buf.sv - glyph string buffer, synchronous write, asynchronous read, not cleared by reset
module oled_glyph_buf
  import oled_pkg::*;
(
  input  logic       sys_clk,
  input  logic       i_wr_en,
  input  logic [3:0] i_wr_addr,
  input  logic [5:0] i_wr_sel,
  input  logic [3:0] i_rd_addr,
  output logic [5:0] o_rd_sel
);

  logic [5:0] r_mem [MAX_GLYPHS];

  // Store one font_sel code per slot.
  always_ff @(posedge sys_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_sel;
  end

  assign o_rd_sel = r_mem[i_rd_addr];

endmodule

// File: rtl/oled_glyph_sequencer.sv
// rtl/oled_glyph_sequencer.sv - renders a glyph string into SSD1306 page-mode GDDRAM via the font ROM
module oled_glyph_sequencer
  import oled_pkg::*;
(
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        buf_wr_en,
  input  logic [3:0]  buf_wr_addr,
  input  logic [5:0]  buf_wr_sel,
  input  logic        start,
  input  logic [2:0]  start_page,
  input  logic [6:0]  start_col,
  input  logic [4:0]  glyph_cnt,
  output logic        busy,
  output logic        done,
  output logic        font_row,
  output logic [5:0]  font_sel,
  output logic [8:0]  index,
  input  logic [7:0]  rom_data,
  oled_glyph_sequencer_if.master oled_out
);

  seq_state_t r_state, w_next;

  logic [4:0] r_cnt;        // clamped glyph count
  logic [4:0] r_gidx;       // current glyph slot, reaches r_cnt at end of string
  logic [2:0] r_page;       // upper page of the current glyph
  logic [7:0] r_col;        // 0..128; 128 means the line is exactly full
  logic       r_row;        // 0 upper page, 1 lower page
  logic [3:0] r_k;          // column within the glyph
  logic       r_font_row;
  logic [5:0] r_font_sel;
  logic [8:0] r_index;

  logic [5:0] w_cur_sel;
  logic [4:0] w_width;
  logic       w_wrap;
  logic       w_last;
  logic [2:0] w_row_page;
  logic       w_emit;
  logic       w_dc;
  logic [7:0] w_byte;
  logic       w_hs;
  logic       w_busy;

  oled_glyph_buf u_buf (
    .sys_clk   (sys_clk),
    .i_wr_en   (buf_wr_en & ~w_busy),
    .i_wr_addr (buf_wr_addr),
    .i_wr_sel  (buf_wr_sel),
    .i_rd_addr (r_gidx[3:0]),
    .o_rd_sel  (w_cur_sel)
  );

  assign w_width    = glyph_width(w_cur_sel);
  assign w_wrap     = ({1'b0, r_col} + {4'b0, w_width}) > 9'(OLED_COLS);
  assign w_last     = ({1'b0, r_k} == (w_width - 5'd1));
  assign w_row_page = r_page + {2'b00, r_row};
  assign w_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_hs       = w_emit & oled_out.out_ready;

  // State register; reset drops straight to IDLE so the stream is cut immediately.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and stream fields; stream depends only on state and held registers, so it is stable while stalled.
  always_comb begin
    w_next = r_state;
    w_emit = 1'b0;
    w_dc   = 1'b0;
    w_byte = 8'h00;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = (glyph_cnt == 5'd0) ? S_DONE : S_NEXT_GLYPH;
        else       w_next = S_IDLE;
      end
      S_NEXT_GLYPH: begin
        if (r_gidx == r_cnt)       w_next = S_DONE;
        else if (w_width != 5'd0)  w_next = S_CMD_PAGE;
      end
      S_CMD_PAGE: begin
        w_emit = 1'b1;
        w_byte = CMD_SET_PAGE | {5'b0, w_row_page};
        if (oled_out.out_ready) w_next = S_CMD_COLL;
      end
      S_CMD_COLL: begin
        w_emit = 1'b1;
        w_byte = CMD_COL_LO | {4'b0, r_col[3:0]};
        if (oled_out.out_ready) w_next = S_CMD_COLH;
      end
      S_CMD_COLH: begin
        w_emit = 1'b1;
        w_byte = CMD_COL_HI | {5'b0, r_col[6:4]};
        if (oled_out.out_ready) w_next = S_FETCH;
      end
      S_FETCH: w_next = S_DATA;
      S_DATA: begin
        w_emit = 1'b1;
        w_dc   = 1'b1;
        w_byte = rom_data;
        if (oled_out.out_ready) begin
          if (!w_last)    w_next = S_FETCH;
          else if (r_row) w_next = S_NEXT_GLYPH;
          else            w_next = S_NEXT_ROW;
        end
      end
      S_NEXT_ROW: w_next = S_CMD_PAGE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Position counters and ROM address registers; ROM inputs change only when entering FETCH.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= 5'd0;
      r_gidx     <= 5'd0;
      r_page     <= 3'd0;
      r_col      <= 8'd0;
      r_row      <= 1'b0;
      r_k        <= 4'd0;
      r_font_row <= 1'b0;
      r_font_sel <= 6'd0;
      r_index    <= 9'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cnt  <= (glyph_cnt > 5'(MAX_GLYPHS)) ? 5'(MAX_GLYPHS) : glyph_cnt;
            r_gidx <= 5'd0;
            r_page <= start_page;
            r_col  <= {1'b0, start_col};
            r_row  <= 1'b0;
          end
        end
        S_NEXT_GLYPH: begin
          if (r_gidx != r_cnt) begin
            if (w_width == 5'd0) begin
              r_gidx <= r_gidx + 5'd1;
            end else if (w_wrap) begin
              r_col  <= 8'd0;
              r_page <= r_page + 3'd2;
            end
          end
        end
        S_CMD_COLH: begin
          if (w_hs) begin
            r_k        <= 4'd0;
            r_font_sel <= w_cur_sel;
            r_font_row <= r_row;
            r_index    <= 9'd0;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            if (!w_last) begin
              r_k     <= r_k + 4'd1;
              r_index <= {5'b0, r_k + 4'd1};
            end else if (r_row) begin
              r_row  <= 1'b0;
              r_col  <= r_col + {3'b0, w_width};
              r_gidx <= r_gidx + 5'd1;
            end
          end
        end
        S_NEXT_ROW: r_row <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy               = w_busy;
  assign done               = (r_state == S_DONE);
  assign font_row           = r_font_row;
  assign font_sel           = r_font_sel;
  assign index              = r_index;
  assign oled_out.out_valid = w_emit;
  assign oled_out.out_dc    = w_dc;
  assign oled_out.out_byte  = w_byte;

endmodule

// File: tb/tb_oled_glyph_sequencer.sv
// tb/tb_oled_glyph_sequencer.sv - directed vector bench for the OLED glyph sequencer
module tb_oled_glyph_sequencer;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       buf_wr_en;
  logic [3:0] buf_wr_addr;
  logic [5:0] buf_wr_sel;
  logic       start;
  logic [2:0] start_page;
  logic [6:0] start_col;
  logic [4:0] glyph_cnt;
  logic       busy;
  logic       done;
  logic       font_row;
  logic [5:0] font_sel;
  logic [8:0] index;
  logic [7:0] rom_data;

  oled_glyph_sequencer_if bus ();

  oled_glyph_sequencer dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_sel  (buf_wr_sel),
    .start       (start),
    .start_page  (start_page),
    .start_col   (start_col),
    .glyph_cnt   (glyph_cnt),
    .busy        (busy),
    .done        (done),
    .font_row    (font_row),
    .font_sel    (font_sel),
    .index       (index),
    .rom_data    (rom_data),
    .oled_out    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Font ROM stand-in: 'R' (sel 12) holds real bitmap bytes, other codes a unique per-byte pattern.
  function automatic logic [7:0] rom_fn(input logic [5:0] s, input logic r, input logic [8:0] i);
    logic [7:0] v;
    if (s == 6'd12) begin
      case ({r, i[2:0]})
        4'h0: v = 8'h08; 4'h1: v = 8'hF8; 4'h2: v = 8'h88; 4'h3: v = 8'h88;
        4'h4: v = 8'h88; 4'h5: v = 8'h88; 4'h6: v = 8'h70; 4'h7: v = 8'h00;
        4'h8: v = 8'h20; 4'h9: v = 8'h3F; 4'hA: v = 8'h20; 4'hB: v = 8'h00;
        4'hC: v = 8'h03; 4'hD: v = 8'h0C; 4'hE: v = 8'h30; default: v = 8'h20;
      endcase
    end else begin
      v = {s[2:0], r, i[3:0]};
    end
    return v;
  endfunction

  always @(posedge sys_clk) rom_data <= rom_fn(font_sel, font_row, index);

  function automatic int tb_width(input int s);
    if (s == 0 || s == 1 || s == 10 || s == 12 || s == 13 || s == 14) return 8;
    if (s >= 2 && s <= 11) return 16;
    return 0;
  endfunction

  typedef struct {
    int          fill;
    int          s0, s1, s2;
    int          cnt, page, col, pct;
    int          len;
    int          k;
    logic [23:0] first;
    logic [23:0] at_k;
  } vec_t;

  vec_t       vecs [9];
  int         tb_sel [16];
  logic [8:0] got [$];
  logic [8:0] exp_q [$];
  logic [8:0] r_lit [22];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] byte3(input int i);
    logic [23:0] v;
    v = 24'hFFFFFF;
    if (got.size() >= i + 3) v = {got[i][7:0], got[i+1][7:0], got[i+2][7:0]};
    return v;
  endfunction

  task automatic write_all(input int fill, input int s0, input int s1, input int s2);
    for (int a = 0; a < 16; a++) begin
      @(negedge sys_clk);
      buf_wr_en   = 1'b1;
      buf_wr_addr = 4'(a);
      tb_sel[a]   = (a == 0) ? s0 : (a == 1) ? s1 : (a == 2) ? s2 : fill;
      buf_wr_sel  = 6'(tb_sel[a]);
    end
    @(negedge sys_clk);
    buf_wr_en = 1'b0;
  endtask

  task automatic build_exp(input int cnt, input int page, input int col);
    int n, p, c, w;
    exp_q.delete();
    n = (cnt > 16) ? 16 : cnt;
    p = page;
    c = col;
    for (int g = 0; g < n; g++) begin
      w = tb_width(tb_sel[g]);
      if (w != 0) begin
        if (c + w > 128) begin
          c = 0;
          p = (p + 2) % 8;
        end
        for (int r = 0; r < 2; r++) begin
          exp_q.push_back({1'b0, 8'hB0 | 8'((p + r) % 8)});
          exp_q.push_back({1'b0, 8'(c % 16)});
          exp_q.push_back({1'b0, 8'h10 | 8'(c / 16)});
          for (int k = 0; k < w; k++) exp_q.push_back({1'b1, rom_fn(6'(tb_sel[g]), 1'(r), 9'(k))});
        end
        c = c + w;
      end
    end
  endtask

  // Collects bytes until done, checking that a stalled byte stays put.
  task automatic collect(input int pct, input string tag);
    bit         seen_done;
    logic       pv, pr;
    logic [8:0] pb;
    got.delete();
    seen_done = 0;
    pv = 0; pr = 0; pb = 9'h0;
    for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
      @(negedge sys_clk);
      start = 1'b0;
      bus.out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      #1;
      if (pv && !pr) check({tag, " stall hold"}, {23'h0, bus.out_valid, bus.out_dc, bus.out_byte}, {23'h0, 1'b1, pb});
      if (bus.out_valid && bus.out_ready) got.push_back({bus.out_dc, bus.out_byte});
      pv = bus.out_valid;
      pr = bus.out_ready;
      pb = {bus.out_dc, bus.out_byte};
      if (done) begin
        seen_done = 1;
        check({tag, " busy at done"}, 32'(busy), 32'h0);
      end
    end
    check({tag, " done seen"}, 32'(seen_done), 32'h1);
    @(negedge sys_clk);
    #1;
    check({tag, " done one cycle"}, 32'(done), 32'h0);
  endtask

  task automatic run(input int cnt, input int page, input int col, input int pct, input string tag);
    @(negedge sys_clk);
    start      = 1'b1;
    glyph_cnt  = 5'(cnt);
    start_page = 3'(page);
    start_col  = 7'(col);
    collect(pct, tag);
  endtask

  task automatic compare_stream(input string tag);
    int bad;
    bad = 0;
    check({tag, " length"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
    check({tag, " bytes differing"}, 32'(bad), 32'h0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'h0);
    check({tag, " out_dc"},    32'(bus.out_dc),    32'h0);
    check({tag, " out_byte"},  32'(bus.out_byte),  32'h0);
    check({tag, " busy"},      32'(busy),          32'h0);
    check({tag, " done"},      32'(done),          32'h0);
    check({tag, " font_rsi"},  {16'h0, font_row, font_sel, index}, 32'h0);
  endtask

  initial begin
    bit found;
    r_lit = '{9'h0B0, 9'h000, 9'h010,
              9'h108, 9'h1F8, 9'h188, 9'h188, 9'h188, 9'h188, 9'h170, 9'h100,
              9'h0B1, 9'h000, 9'h010,
              9'h120, 9'h13F, 9'h120, 9'h100, 9'h103, 9'h10C, 9'h130, 9'h120};
    //          fill s0  s1 s2 cnt pg col pct len  k    first        at_k
    vecs[0] = '{0,  12, 0, 0,  1, 0,   0, 100,  22,  11, 24'hB00010, 24'hB10010};
    vecs[1] = '{0,   2, 3, 0,  2, 0,   0, 100,  76,  38, 24'hB00010, 24'hB00011};
    vecs[2] = '{0,   2, 0, 0,  1, 2, 120, 100,  38,  19, 24'hB40010, 24'hB50010};
    vecs[3] = '{0,   2, 3, 0,  2, 0,   0,  25,  76,  38, 24'hB00010, 24'hB00011};
    vecs[4] = '{0,   0, 20, 1, 3, 1,   0, 100,  44,  22, 24'hB10010, 24'hB10810};
    vecs[5] = '{0,  10, 0, 0,  1, 7,   5, 100,  22,  11, 24'hB70510, 24'hB00510};
    vecs[6] = '{0,   0, 0, 0, 20, 0,   0, 100, 352, 330, 24'hB00010, 24'hB00817};
    vecs[7] = '{0,   2, 0, 0,  1, 6, 120,  25,  38,  19, 24'hB00010, 24'hB10010};
    vecs[8] = '{15,  5, 0, 0,  3, 3, 112, 100,  82,  38, 24'hB30017, 24'hB50010};

    rst = 1'b1;
    buf_wr_en = 1'b0; buf_wr_addr = 4'h0; buf_wr_sel = 6'h0;
    start = 1'b0; start_page = 3'h0; start_col = 7'h0; glyph_cnt = 5'h0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    check_outputs_zero("reset");
    @(negedge sys_clk);
    rst = 1'b0;

    // glyph_cnt = 0: done on the next cycle, busy never raised
    @(negedge sys_clk);
    start = 1'b1; glyph_cnt = 5'd0;
    @(negedge sys_clk);
    start = 1'b0;
    #1;
    check("cnt0 done", 32'(done), 32'h1);
    check("cnt0 busy", 32'(busy), 32'h0);
    @(negedge sys_clk);
    #1;
    check("cnt0 done drop", 32'(done), 32'h0);
    check("cnt0 busy after", 32'(busy), 32'h0);

    // table-driven renders
    foreach (vecs[v]) begin
      write_all(vecs[v].fill, vecs[v].s0, vecs[v].s1, vecs[v].s2);
      build_exp(vecs[v].cnt, vecs[v].page, vecs[v].col);
      run(vecs[v].cnt, vecs[v].page, vecs[v].col, vecs[v].pct, $sformatf("vec%0d", v));
      check($sformatf("vec%0d len", v),   32'(got.size()), 32'(vecs[v].len));
      check($sformatf("vec%0d first", v), {8'h0, byte3(0)}, {8'h0, vecs[v].first});
      check($sformatf("vec%0d at_k", v),  {8'h0, byte3(vecs[v].k)}, {8'h0, vecs[v].at_k});
      compare_stream($sformatf("vec%0d", v));
    end

    // start and buffer write while busy are both ignored
    write_all(0, 12, 0, 0);
    @(negedge sys_clk);
    start = 1'b1; glyph_cnt = 5'd1; start_page = 3'd0; start_col = 7'd0;
    bus.out_ready = 1'b0;
    @(negedge sys_clk);
    start = 1'b0;
    #1;
    check("ignore busy", 32'(busy), 32'h1);
    @(negedge sys_clk);
    buf_wr_en = 1'b1; buf_wr_addr = 4'd0; buf_wr_sel = 6'd2;
    start = 1'b1; glyph_cnt = 5'd3; start_page = 3'd5; start_col = 7'd40;
    @(negedge sys_clk);
    buf_wr_en = 1'b0; start = 1'b0;
    build_exp(1, 0, 0);
    collect(100, "ignore");
    compare_stream("ignore");

    // reset in the middle of a stalled data byte, then a clean render
    @(negedge sys_clk);
    start = 1'b1; glyph_cnt = 5'd1; start_page = 3'd0; start_col = 7'd0;
    found = 0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge sys_clk);
      start = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && bus.out_dc) begin
        bus.out_ready = 1'b0;
        found = 1;
      end
    end
    check("midrst reached data", 32'(found), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    @(negedge sys_clk);
    rst = 1'b0;
    run(1, 0, 0, 100, "after_rst");
    check("after_rst len", 32'(got.size()), 32'd22);
    for (int i = 0; i < 22; i++)
      check($sformatf("after_rst byte%0d", i), 32'(got.size() > i ? got[i] : 9'h1FF), 32'(r_lit[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
